mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the CPU's 8-bit data bus, downstream of the core.

---
 rtl/mmio_uart_tx.sv | 199 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a small TX FIFO.
// A 4-byte register window at BASE_ADDR feeds an 8N1 serialiser.
// Optional build macro: UART_PARITY_EN adds an even-parity bit (8E1).
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   address[7:0]        CPU bus address
//   write_enable        CPU write strobe; one write per rising strobe
//   write_data[7:0]     CPU write data
//   read_data[7:0]      register read data, combinational from address
//   selected            address falls inside the window, combinational
//   tx                  serial output, idle high
//   irq_empty           FIFO empty and transmitter idle (registered)
// Registers: 0 DATA (W push), 1 STATUS {count,ovf,busy,empty,full},
//            2 DIV (bit period = DIV+1 clocks), 3 reserved.
module mmio_uart_tx #(
    parameter logic [7:0] BASE_ADDR       = 8'hFC,
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [7:0] DEFAULT_DIVISOR = 8'd103
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] address,
    input  logic       write_enable,
    input  logic [7:0] write_data,
    output logic [7:0] read_data,
    output logic       selected,
    output logic       tx,
    output logic       irq_empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic          r_we_q;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [7:0]    r_div;
    state_t        r_state;
    logic [7:0]    r_shift;
    logic [7:0]    r_div_act;
    logic [7:0]    r_timer;
    logic [2:0]    r_bitcnt;
    logic          r_irq;
`ifdef UART_PARITY_EN
    logic          r_par;
`endif

    logic          w_wr;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_busy;
    logic          w_bit_end;
    state_t        w_state_n;
    logic [7:0]    w_shift_n;
    logic [7:0]    w_div_act_n;
    logic [7:0]    w_timer_n;
    logic [2:0]    w_bitcnt_n;

    assign selected   = (address[7:2] == BASE_ADDR[7:2]);
    // Edge-detect the strobe so a held write_enable produces one write.
    assign w_wr       = write_enable & ~r_we_q & selected;
    assign w_push_req = w_wr & (address[1:0] == 2'd0);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_busy     = (r_state != S_IDLE);
    // A pop in the same cycle frees a slot, so a push into a full FIFO lands.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign irq_empty  = r_irq;

    always_comb begin
        read_data = 8'h00;
        if (selected) begin
            unique case (address[1:0])
                2'd1:    read_data = {4'(r_count), r_ovf, w_busy,
                                      w_empty, w_full};
                2'd2:    read_data = r_div;
                default: read_data = 8'h00;
            endcase
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_shift_n   = r_shift;
        w_div_act_n = r_div_act;
        w_bitcnt_n  = r_bitcnt;
        w_pop       = 1'b0;
        tx          = 1'b1;
        w_bit_end   = (r_timer == r_div_act);
        w_timer_n   = w_bit_end ? 8'd0 : r_timer + 8'd1;
        unique case (r_state)
            S_IDLE: begin
                w_timer_n = 8'd0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_n   = r_mem[r_rptr];
                    w_div_act_n = r_div;
                    w_bitcnt_n  = 3'd0;
                    w_state_n   = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (w_bit_end) w_state_n = S_DATA;
            end
            S_DATA: begin
                tx = r_shift[0];
                if (w_bit_end) begin
                    w_shift_n  = {1'b0, r_shift[7:1]};
                    w_bitcnt_n = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_state_n = S_PARITY;
`else
                        w_state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                tx = r_par;
                if (w_bit_end) w_state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_end) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= write_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_q    <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_div     <= DEFAULT_DIVISOR;
            r_state   <= S_IDLE;
            r_shift   <= 8'h00;
            r_div_act <= 8'h00;
            r_timer   <= 8'h00;
            r_bitcnt  <= 3'd0;
            r_irq     <= 1'b1;
        end else begin
            r_we_q    <= write_enable;
            r_state   <= w_state_n;
            r_shift   <= w_shift_n;
            r_div_act <= w_div_act_n;
            r_timer   <= w_timer_n;
            r_bitcnt  <= w_bitcnt_n;
            r_irq     <= w_empty & ~w_busy;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req & ~w_push)
                r_ovf <= 1'b1;
            else if (w_wr & (address[1:0] == 2'd1))
                r_ovf <= 1'b0;
            if (w_wr & (address[1:0] == 2'd2))
                r_div <= write_data;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_par <= 1'b0;
        else if (w_pop) r_par <= ^r_mem[r_rptr];
    end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx.
// Frames are decoded from tx and compared against hand-built bit patterns.
module tb_mmio_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] address = 8'h00;
    logic       write_enable = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic [7:0] read_data;
    logic       selected;
    logic       tx;
    logic       irq_empty;

    int n_chk = 0;
    int n_err = 0;

`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    mmio_uart_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .write_enable(write_enable),
        .write_data  (write_data),
        .read_data   (read_data),
        .selected    (selected),
        .tx          (tx),
        .irq_empty   (irq_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        address      = a;
        write_data   = d;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                      input string tag);
        address = a;
        #1;
        chk(tag, read_data, exp);
    endtask

    task automatic check_frame(input logic [7:0] d, input int p,
                               input string tag);
        logic [NB-1:0] e;
        int t;
        e[0] = 1'b0;
        for (int i = 0; i < 8; i++) e[i+1] = d[i];
`ifdef UART_PARITY_EN
        e[9] = ^d;
`endif
        e[NB-1] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (tx !== 1'b0 && t < 300);
        if (tx !== 1'b0) begin
            chk({tag, " start"}, tx, 0);
            return;
        end
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < p; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                if (j == 0 || j == p - 1)
                    chk($sformatf("%s bit%0d", tag, k), tx, e[k]);
            end
        end
        address = 8'hFD;
        #1;
        chk({tag, " busy_last"}, read_data[2], 1);
        @(negedge clk);
        #1;
        chk({tag, " busy_clear"}, read_data[2], 0);
        chk({tag, " tx_idle"}, tx, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_irq", irq_empty, 1);
        rd(8'hFD, 8'h02, "rst_status");
        rd(8'hFE, 8'd103, "rst_div");
        rst_n = 1'b1;

        bus_write(8'hFE, 8'd3);
        rd(8'hFE, 8'd3, "div3");
        bus_write(8'hFC, 8'hA5);
        check_frame(8'hA5, 4, "a5");
        @(negedge clk);
        chk("a5_irq", irq_empty, 1);

        fork
            begin
                address      = 8'hFC;
                write_data   = 8'h11;
                write_enable = 1'b1;
                repeat (5) @(negedge clk);
                write_enable = 1'b0;
            end
            check_frame(8'h11, 4, "held");
        join
        repeat (60) @(negedge clk);
        rd(8'hFD, 8'h02, "held_single");

        fork
            begin
                bus_write(8'hFC, 8'h00);
                repeat (10) @(negedge clk);
                bus_write(8'hFE, 8'd7);
                bus_write(8'hFC, 8'h55);
            end
            begin
                check_frame(8'h00, 4, "f00");
                check_frame(8'h55, 8, "f55");
            end
        join
        rd(8'hFE, 8'd7, "div7");

        bus_write(8'hF8, 8'hFF);
        #1;
        chk("dec_sel", selected, 0);
        chk("dec_rd", read_data, 8'h00);
        rd(8'hFD, 8'h02, "dec_status");
        rd(8'hFE, 8'd7, "dec_div");
        rd(8'hFF, 8'h00, "rsvd_rd");
        rd(8'hFC, 8'h00, "data_rd");
        chk("sel_fc", selected, 1);

        bus_write(8'hFE, 8'd0);
        for (int i = 0; i < 6; i++) bus_write(8'hFC, 8'h30 + 8'(i));
        rd(8'hFD, 8'h4D, "ovf_status");
        chk("ovf_irq", irq_empty, 0);
        bus_write(8'hFD, 8'h00);
        address = 8'hFD;
        #1;
        chk("ovf_clr", read_data[3], 0);
        t = 0;
        while (irq_empty !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_irq", irq_empty, 1);
        rd(8'hFD, 8'h02, "drain_status");

        bus_write(8'hFE, 8'd3);
        bus_write(8'hFC, 8'hF0);
        repeat (3) @(negedge clk);
        chk("pre_rst_tx", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_irq", irq_empty, 1);
        rd(8'hFD, 8'h02, "mid_rst_status");
        rd(8'hFE, 8'd103, "mid_rst_div");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_tx", tx, 1);
        rd(8'hFD, 8'h02, "post_rst_status");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
